// File: rtl/hsv_convert_pipe.sv
// Pipelined RGB (or RGB565) to HSV converter with valid/ready flow control and a sideband user field.
// Stage A finds max/min/sector, N = max(6, CH_W) restoring-divider stages, then one output stage.
module hsv_convert_pipe #(
    parameter int CH_W   = 8,
    parameter int RGB565 = 0,
    parameter int USER_W = 2,
    localparam int IN_W  = (RGB565 != 0) ? 16 : 3 * CH_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [IN_W-1:0]   i_data,
    input  logic [USER_W-1:0] i_user,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [8:0]        o_hue,
    output logic [CH_W-1:0]   o_sat,
    output logic [CH_W-1:0]   o_val,
    output logic [USER_W-1:0] o_user,
    output logic              o_valid,
    input  logic              i_ready
);
    localparam int N  = (CH_W > 6) ? CH_W : 6;
    localparam int RW = CH_W + N;
    localparam logic [RW-1:0] CH_MAX = RW'((1 << CH_W) - 1);

    logic [CH_W-1:0] w_r, w_g, w_b;

    generate
        if (RGB565 != 0) begin : g_565
            assign w_r = {i_data[15:11], i_data[15:13]};
            assign w_g = {i_data[10:5],  i_data[10:9]};
            assign w_b = {i_data[4:0],   i_data[4:2]};
        end else begin : g_rgb
            assign w_r = i_data[3*CH_W-1:2*CH_W];
            assign w_g = i_data[2*CH_W-1:CH_W];
            assign w_b = i_data[CH_W-1:0];
        end
    endgenerate

    logic            w_ce;
    logic [CH_W-1:0] w_mx, w_mn, w_dlt, w_dmag;
    logic [1:0]      w_sec;
    logic            w_sgn;

    assign w_ce    = i_ready | ~o_valid;
    assign o_ready = w_ce;

    // Ties resolve R over G over B so the comparisons below are ordered on purpose.
    always_comb begin
        w_sec  = 2'd0;
        w_mx   = w_r;
        w_sgn  = 1'b0;
        w_dmag = '0;
        if (w_r >= w_g && w_r >= w_b) begin
            w_sec  = 2'd0;
            w_mx   = w_r;
            w_sgn  = (w_g < w_b);
            w_dmag = w_sgn ? (w_b - w_g) : (w_g - w_b);
        end else if (w_g >= w_b) begin
            w_sec  = 2'd1;
            w_mx   = w_g;
            w_sgn  = (w_b < w_r);
            w_dmag = w_sgn ? (w_r - w_b) : (w_b - w_r);
        end else begin
            w_sec  = 2'd2;
            w_mx   = w_b;
            w_sgn  = (w_r < w_g);
            w_dmag = w_sgn ? (w_g - w_r) : (w_r - w_g);
        end
        w_mn = (w_r < w_g) ? w_r : w_g;
        if (w_b < w_mn) w_mn = w_b;
        w_dlt = w_mx - w_mn;
    end

    logic              r_vld  [0:N];
    logic [USER_W-1:0] r_user [0:N];
    logic [CH_W-1:0]   r_mx   [0:N];
    logic [CH_W-1:0]   r_dlt  [0:N];
    logic              r_sgn  [0:N];
    logic [1:0]        r_sec  [0:N];
    logic [RW-1:0]     r_rh   [0:N];
    logic [RW-1:0]     r_rs   [0:N];
    logic [N-1:0]      r_qh   [0:N];
    logic [N-1:0]      r_qs   [0:N];

    logic [RW-1:0]     w_rh   [1:N];
    logic [RW-1:0]     w_rs   [1:N];
    logic [N-1:0]      w_qh   [1:N];
    logic [N-1:0]      w_qs   [1:N];

    // Stage k resolves quotient bit N-k; a zero divisor never sets a bit, so the quotient stays 0.
    always_comb begin
        for (int k = 1; k <= N; k++) begin
            w_rh[k] = r_rh[k-1];
            w_qh[k] = r_qh[k-1];
            w_rs[k] = r_rs[k-1];
            w_qs[k] = r_qs[k-1];
            if (r_dlt[k-1] != '0 && r_rh[k-1] >= (RW'(r_dlt[k-1]) << (N - k))) begin
                w_rh[k]      = r_rh[k-1] - (RW'(r_dlt[k-1]) << (N - k));
                w_qh[k][N-k] = 1'b1;
            end
            if (r_mx[k-1] != '0 && r_rs[k-1] >= (RW'(r_mx[k-1]) << (N - k))) begin
                w_rs[k]      = r_rs[k-1] - (RW'(r_mx[k-1]) << (N - k));
                w_qs[k][N-k] = 1'b1;
            end
        end
    end

    logic [10:0] w_hq, w_hraw;
    logic [8:0]  w_hue;

    always_comb begin
        w_hq = 11'(r_qh[N]);
        case (r_sec[N])
            2'd1:    w_hraw = 11'd120;
            2'd2:    w_hraw = 11'd240;
            default: w_hraw = 11'd0;
        endcase
        w_hraw = r_sgn[N] ? (w_hraw - w_hq) : (w_hraw + w_hq);
        w_hue  = w_hraw[10] ? 9'(w_hraw + 11'd360) : w_hraw[8:0];
    end

    logic              r_ovld;
    logic [8:0]        r_hue;
    logic [CH_W-1:0]   r_sat;
    logic [CH_W-1:0]   r_val;
    logic [USER_W-1:0] r_ouser;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int k = 0; k <= N; k++) r_vld[k] <= 1'b0;
            r_ovld  <= 1'b0;
            r_hue   <= '0;
            r_sat   <= '0;
            r_val   <= '0;
            r_ouser <= '0;
        end else if (w_ce) begin
            r_vld[0] <= i_valid;
            for (int k = 1; k <= N; k++) r_vld[k] <= r_vld[k-1];
            r_ovld  <= r_vld[N];
            r_hue   <= w_hue;
            r_sat   <= r_qs[N][CH_W-1:0];
            r_val   <= r_mx[N];
            r_ouser <= r_user[N];
        end
    end

    // Datapath registers need no reset: only the valid bits qualify them.
    always_ff @(posedge i_clk) begin
        if (w_ce) begin
            r_user[0] <= i_user;
            r_mx[0]   <= w_mx;
            r_dlt[0]  <= w_dlt;
            r_sgn[0]  <= w_sgn;
            r_sec[0]  <= w_sec;
            r_rh[0]   <= RW'(w_dmag) * RW'(60);
            r_rs[0]   <= RW'(w_dlt) * CH_MAX;
            r_qh[0]   <= '0;
            r_qs[0]   <= '0;
            for (int k = 1; k <= N; k++) begin
                r_user[k] <= r_user[k-1];
                r_mx[k]   <= r_mx[k-1];
                r_dlt[k]  <= r_dlt[k-1];
                r_sgn[k]  <= r_sgn[k-1];
                r_sec[k]  <= r_sec[k-1];
                r_rh[k]   <= w_rh[k];
                r_rs[k]   <= w_rs[k];
                r_qh[k]   <= w_qh[k];
                r_qs[k]   <= w_qs[k];
            end
        end
    end

    assign o_valid = r_ovld;
    assign o_hue   = r_hue;
    assign o_sat   = r_sat;
    assign o_val   = r_val;
    assign o_user  = r_ouser;

endmodule

// File: tb/tb_hsv_convert_pipe.sv
// Directed and random checks of hsv_convert_pipe: a queue of expected {hue,sat,val,user}
// is filled at each accepted input and drained in order at each accepted output.
module tb_hsv_convert_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn = 1'b0;
    logic        vld  = 1'b0;
    logic        rdy  = 1'b1;
    logic [23:0] data = '0;
    logic [1:0]  user = '0;
    logic        o_ready, o_valid;
    logic [8:0]  o_hue;
    logic [7:0]  o_sat, o_val;
    logic [1:0]  o_user;

    logic        b_vld  = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ready, b_valid;
    logic [8:0]  b_hue;
    logic [7:0]  b_sat, b_val;
    logic [1:0]  b_user;

    hsv_convert_pipe #(.CH_W(8), .RGB565(0), .USER_W(2)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_user(user), .i_valid(vld),
        .o_ready(o_ready), .o_hue(o_hue), .o_sat(o_sat), .o_val(o_val),
        .o_user(o_user), .o_valid(o_valid), .i_ready(rdy)
    );

    hsv_convert_pipe #(.CH_W(8), .RGB565(1), .USER_W(2)) u_dut565 (
        .i_clk(clk), .i_rstn(rstn), .i_data(b_data), .i_user(2'd0), .i_valid(b_vld),
        .o_ready(b_ready), .o_hue(b_hue), .o_sat(b_sat), .o_val(b_val),
        .o_user(b_user), .o_valid(b_valid), .i_ready(1'b1)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [26:0] q[$];
    logic        lat_arm = 1'b0;
    int          lat_start = 0;
    int          lat_obs = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] hsv(input int h, input int s, input int v);
        return {9'(h), 8'(s), 8'(v)};
    endfunction

    function automatic logic [24:0] model(input logic [23:0] p);
        int r, g, b, mx, mn, dl, h, s;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        dl = mx - mn;
        if (dl == 0)      h = 0;
        else if (r == mx) h = (60 * (g - b)) / dl;
        else if (g == mx) h = 120 + (60 * (b - r)) / dl;
        else              h = 240 + (60 * (r - g)) / dl;
        if (h < 0) h += 360;
        s = (mx == 0) ? 0 : (dl * 255) / mx;
        return hsv(h, s, mx);
    endfunction

    // One clock: drive inputs after the edge, then check any output and record any accepted input.
    task automatic step(input logic r_n, input logic v, input logic [23:0] d, input logic [1:0] u,
                        input logic rd, input logic [24:0] exp_hsv);
        logic [26:0] e;
        @(posedge clk);
        #1;
        rstn = r_n; vld = v; data = d; user = u; rdy = rd;
        #1;
        cyc++;
        if (lat_arm && o_valid) begin
            lat_obs = cyc - lat_start;
            lat_arm = 1'b0;
        end
        if (o_valid && r_n) begin
            chk("output_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = rd ? q.pop_front() : q[0];
                chk(rd ? "output_hsvu" : "stall_hsvu", 32'({o_hue, o_sat, o_val, o_user}), 32'(e));
            end
        end
        if (v && o_ready && r_n) q.push_back({exp_hsv, u});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b1, 1'b0, 24'd0, 2'd0, 1'b1, 25'd0);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v565 [3];
        logic [24:0] e565 [3];
        logic [23:0] p;
        logic        v, rd;
        int          n, acc;

        // Reset state
        step(1'b0, 1'b0, 24'd0, 2'd0, 1'b1, 25'd0);
        step(1'b0, 1'b0, 24'd0, 2'd0, 1'b1, 25'd0);
        step(1'b1, 1'b0, 24'd0, 2'd0, 1'b0, 25'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_hue",   32'(o_hue),   32'd0);
        chk("rst_o_sat",   32'(o_sat),   32'd0);
        chk("rst_o_val",   32'(o_val),   32'd0);
        chk("rst_o_user",  32'(o_user),  32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);

        // Primaries back to back with latency measurement, then corner pixels
        step(1'b1, 1'b1, 24'hFF0000, 2'd1, 1'b1, hsv(0, 255, 255));
        lat_start = cyc;
        lat_arm   = 1'b1;
        step(1'b1, 1'b1, 24'h00FF00, 2'd2, 1'b1, hsv(120, 255, 255));
        step(1'b1, 1'b1, 24'h0000FF, 2'd3, 1'b1, hsv(240, 255, 255));
        step(1'b1, 1'b1, 24'h808080, 2'd0, 1'b1, hsv(0, 0, 128));
        step(1'b1, 1'b1, 24'h000000, 2'd1, 1'b1, hsv(0, 0, 0));
        step(1'b1, 1'b1, 24'hFF0080, 2'd2, 1'b1, hsv(330, 255, 255));
        step(1'b1, 1'b1, 24'h80FF00, 2'd3, 1'b1, hsv(90, 255, 255));
        step(1'b1, 1'b1, 24'hFFFF00, 2'd0, 1'b1, hsv(60, 255, 255));
        drain("directed_drain");
        chk("latency", 32'(lat_obs), 32'd10);

        // Backpressure: fill, stall 5 cycles while offering a pixel, release
        for (int i = 0; i < 12; i++) begin
            p = 24'h102030 + 24'(i) * 24'h0B1307;
            step(1'b1, 1'b1, p, 2'(i), 1'b1, model(p));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 24'h123456, 2'd3, 1'b0, model(24'h123456));
            chk("stall_o_ready", 32'(o_ready), 32'd0);
            chk("stall_o_valid", 32'(o_valid), 32'd1);
        end
        drain("backpressure_drain");

        // RGB565 instance
        v565[0] = 16'hF800; e565[0] = hsv(0, 255, 255);
        v565[1] = 16'h07E0; e565[1] = hsv(120, 255, 255);
        v565[2] = 16'h0000; e565[2] = hsv(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            b_vld = 1'b1; b_data = v565[i];
        end
        @(posedge clk); #1;
        b_vld = 1'b0;
        n = 0;
        for (int t = 0; t < 30 && n < 3; t++) begin
            @(posedge clk); #2;
            if (b_valid) begin
                chk("rgb565_hsv", 32'({b_hue, b_sat, b_val}), 32'(e565[n]));
                n++;
            end
        end
        chk("rgb565_count", 32'(n), 32'd3);

        // Reset mid-stream with i_ready low and outputs pending
        for (int i = 0; i < 12; i++) begin
            p = 24'h405060 + 24'(i) * 24'h071D2B;
            step(1'b1, 1'b1, p, 2'(i), 1'b1, model(p));
        end
        step(1'b0, 1'b1, 24'hABCDEF, 2'd1, 1'b0, 25'd0);
        step(1'b1, 1'b0, 24'd0, 2'd0, 1'b0, 25'd0);
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_ready", 32'(o_ready), 32'd1);
        q.delete();
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 24'd0, 2'd0, 1'b1, 25'd0);
        chk("midrst_no_stale", 32'(o_valid), 32'd0);

        // Random stress with random valid/ready
        acc = 0;
        for (int i = 0; i < 60000 && acc < 10000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            p  = 24'($urandom);
            if ($urandom_range(0, 7) == 0) p[15:8] = p[23:16];
            if ($urandom_range(0, 7) == 0) p[7:0]  = p[15:8];
            step(1'b1, v, p, 2'($urandom_range(0, 3)), rd, model(p));
            if (v && o_ready) acc++;
        end
        chk("random_accepted", 32'(acc), 32'd10000);
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
